// File: rtl/sbqm.sv
// sbqm: single-bank queue manager; counts people between entry/exit cells.
// Ports: Clk/Reset, SenseIn/SenseOut (active-low), TellerCount in; PeopleCount, flags, WaitTime out.
module sbqm #(
  parameter int MAX_COUNT    = 7,
  parameter int SERVICE_TIME = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       SenseIn,
  input  logic       SenseOut,
  input  logic [1:0] TellerCount,
  output logic [2:0] PeopleCount,
  output logic       FullFlag,
  output logic       EmptyFlag,
  output logic [4:0] WaitTime
);

  localparam logic [2:0] MaxCnt = 3'(MAX_COUNT);

  logic [2:0] count_q, count_d;
  logic       full_q, full_d;
  logic       empty_q, empty_d;
  logic       prev_in_q, prev_in_d;
  logic       prev_out_q, prev_out_d;
  logic       arrive, depart;

  // A sensor event is the 1->0 transition of the beam.
  assign arrive = prev_in_q & ~SenseIn;
  assign depart = prev_out_q & ~SenseOut;

  always_comb begin
    count_d    = count_q;
    prev_in_d  = SenseIn;
    prev_out_d = SenseOut;
    unique case ({arrive, depart})
      2'b10: if (count_q != MaxCnt) count_d = count_q + 3'd1;
      2'b01: if (count_q != 3'd0) count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == MaxCnt);
    empty_d = (count_d == 3'd0);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q    <= 3'd0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      prev_in_q  <= 1'b1;
      prev_out_q <= 1'b1;
    end else begin
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      prev_in_q  <= prev_in_d;
      prev_out_q <= prev_out_d;
    end
  end

  // Wait estimate: ceil-style SERVICE_TIME*(P+T-1)/T; dividers are small constants.
  logic [1:0] t_eff;
  logic [9:0] num;
  logic [9:0] quo;

  always_comb begin
    t_eff = (TellerCount == 2'd0) ? 2'd1 : TellerCount;
    num   = 10'(SERVICE_TIME) * ({7'd0, count_q} + {8'd0, t_eff} - 10'd1);
    quo   = num;
    unique case (t_eff)
      2'd2:    quo = num >> 1;
      2'd3:    quo = num / 10'd3;
      default: quo = num;
    endcase
    if (count_q == 3'd0) quo = 10'd0;
  end

  assign PeopleCount = count_q;
  assign FullFlag    = full_q;
  assign EmptyFlag   = empty_q;
  assign WaitTime    = quo[4:0];

endmodule

// File: tb/tb_sbqm.sv
// tb_sbqm: scoreboard bench for sbqm.
// Drives sensors on negedge, checks queued expectations one cycle later.
module tb_sbqm;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_in;
  logic       s_out;
  logic [1:0] tc;
  logic [2:0] pc;
  logic       full;
  logic       empty;
  logic [4:0] wt;

  int n_tests = 0;
  int n_fail  = 0;

  int m_cnt  = 0;
  bit m_pin  = 1'b1;
  bit m_pout = 1'b1;
  int exp_q[$];

  int t1[7] = '{3, 6, 9, 12, 15, 18, 21};
  int t2[7] = '{3, 4, 6, 7, 9, 10, 12};
  int t3[7] = '{3, 4, 5, 6, 7, 8, 9};

  sbqm dut (
    .Clk(clk),
    .Reset(rst),
    .SenseIn(s_in),
    .SenseOut(s_out),
    .TellerCount(tc),
    .PeopleCount(pc),
    .FullFlag(full),
    .EmptyFlag(empty),
    .WaitTime(wt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int wt_ref(input int p, input int t);
    int te;
    te = (t == 0) ? 1 : t;
    if (p == 0) return 0;
    return (3 * (p + te - 1)) / te;
  endfunction

  // One clock: apply inputs, predict, then compare after the edge.
  task automatic step(input bit r, input bit si, input bit so);
    bit a;
    bit d;
    int e;
    rst   = r;
    s_in  = si;
    s_out = so;
    if (r) begin
      m_cnt  = 0;
      m_pin  = 1'b1;
      m_pout = 1'b1;
    end else begin
      a = m_pin && !si;
      d = m_pout && !so;
      if (a && !d && m_cnt < 7) m_cnt++;
      else if (d && !a && m_cnt > 0) m_cnt--;
      m_pin  = si;
      m_pout = so;
    end
    exp_q.push_back(m_cnt);
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("count", int'(pc), e);
    chk("full", int'(full), int'(e == 7));
    chk("empty", int'(empty), int'(e == 0));
    chk("wait", int'(wt), wt_ref(e, int'(tc)));
  endtask

  task automatic pulse_in();
    step(0, 0, 1);
    step(0, 1, 1);
  endtask

  task automatic pulse_out();
    step(0, 1, 0);
    step(0, 1, 1);
  endtask

  task automatic do_reset();
    step(1, 1, 1);
    step(1, 1, 1);
  endtask

  initial begin
    rst   = 1'b1;
    s_in  = 1'b1;
    s_out = 1'b1;
    tc    = 2'd1;
    @(negedge clk);

    do_reset();
    chk("rst_cnt", int'(pc), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_wait", int'(wt), 0);
    repeat (5) step(0, 1, 1);
    chk("idle_cnt", int'(pc), 0);

    for (int i = 0; i < 9; i++) begin
      pulse_in();
      if (i < 7) chk("up_wait_t1", int'(wt), t1[i]);
    end
    chk("sat_cnt", int'(pc), 7);
    chk("sat_full", int'(full), 1);
    for (int i = 0; i < 9; i++) pulse_out();
    chk("dn_cnt", int'(pc), 0);
    chk("dn_empty", int'(empty), 1);

    for (int i = 0; i < 7; i++) begin
      pulse_in();
      tc = 2'd2;
      #1 chk("wait_t2", int'(wt), t2[i]);
      tc = 2'd3;
      #1 chk("wait_t3", int'(wt), t3[i]);
      tc = 2'd0;
      #1 chk("wait_t0", int'(wt), t1[i]);
      tc = 2'd1;
    end

    do_reset();
    repeat (3) pulse_in();
    step(0, 0, 0);
    step(0, 1, 1);
    chk("both_p3", int'(pc), 3);
    repeat (3) pulse_out();
    step(0, 0, 0);
    step(0, 1, 1);
    chk("both_p0", int'(pc), 0);
    chk("both_p0_empty", int'(empty), 1);
    repeat (7) pulse_in();
    step(0, 0, 0);
    step(0, 1, 1);
    chk("both_p7", int'(pc), 7);
    chk("both_p7_full", int'(full), 1);

    do_reset();
    repeat (2) pulse_in();
    repeat (20) step(0, 0, 1);
    step(0, 1, 1);
    chk("hold_in", int'(pc), 3);
    repeat (20) step(0, 1, 0);
    step(0, 1, 1);
    chk("hold_out", int'(pc), 2);

    repeat (3) pulse_in();
    chk("pre_rst", int'(pc), 5);
    step(1, 0, 1);
    chk("mid_rst_cnt", int'(pc), 0);
    chk("mid_rst_empty", int'(empty), 1);
    chk("mid_rst_wait", int'(wt), 0);
    repeat (3) step(0, 1, 1);
    chk("post_rst", int'(pc), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
